// File: rtl/msfsm_pkg.sv
// Shared definitions for the Petri-net style state-machine component:
// default ring maps, per-transition map slicing and one-hot checking.
package msfsm_pkg;

    localparam int MAX_W   = 64;
    localparam int MAX_MAP = 1024;

    // Four-place ring 0->1->2->3->0, one transition per place
    localparam logic [15:0] DEF_PRE  = 16'h8421;
    localparam logic [15:0] DEF_POST = 16'h1842;

    // Extract slice idx of width w from a flattened map (zero-extended)
    function automatic logic [MAX_W-1:0] map_slice(input logic [MAX_MAP-1:0] map,
                                                   input int idx, input int w);
        logic [MAX_MAP-1:0] sh;
        logic [MAX_W-1:0]   mask;
        sh   = map >> (idx * w);
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        return sh[MAX_W-1:0] & mask;
    endfunction

    // True when zero or one bit is set
    function automatic logic at_most_one(input logic [MAX_W-1:0] v);
        return (v & (v - MAX_W'(1))) == '0;
    endfunction

endpackage

// File: rtl/msfsm_prio_arb.sv
// Fixed-priority arbiter: grants the lowest-index active request.
module msfsm_prio_arb #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);
    // Two's-complement trick isolates the lowest set bit
    assign grant = req & (~req + N'(1));
endmodule

// File: rtl/msfsm_component_param.sv
// One component of a synchronised multi-FSM: one-hot marking over N_PLACES,
// fires at most one member transition per cycle, counts firings, flags illegal requests.
module msfsm_component_param
    import msfsm_pkg::*;
#(
    parameter int                          N_PLACES   = 4,
    parameter int                          N_TRANS    = 4,
    parameter logic [N_TRANS*N_PLACES-1:0] PRE        = DEF_PRE,
    parameter logic [N_TRANS*N_PLACES-1:0] POST       = DEF_POST,
    parameter int                          INIT_PLACE = 0,
    parameter int                          CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_TRANS-1:0]  t_req,
    input  logic [N_TRANS-1:0]  t_sync,
    input  logic                hold,
    input  logic                err_clr,
    output logic [N_PLACES-1:0] p,
    output logic [N_TRANS-1:0]  t_en,
    output logic [N_TRANS-1:0]  fire,
    output logic [CNT_W-1:0]    fire_cnt,
    output logic                err
);

    localparam logic [MAX_MAP-1:0]  PRE_X     = MAX_MAP'(PRE);
    localparam logic [MAX_MAP-1:0]  POST_X    = MAX_MAP'(POST);
    localparam logic [N_PLACES-1:0] INIT_MARK = N_PLACES'(1) << INIT_PLACE;

    logic [N_TRANS-1:0]                member;
    logic [N_TRANS-1:0][N_PLACES-1:0]  post_tbl;
    logic [N_TRANS-1:0]                cand;
    logic [N_TRANS-1:0]                grant;
    logic [N_PLACES-1:0]               p_nxt;
    logic                              err_set;

    for (genvar i = 0; i < N_TRANS; i++) begin : g_tr
        localparam logic [MAX_W-1:0] PRE_W  = map_slice(PRE_X, i, N_PLACES);
        localparam logic [MAX_W-1:0] POST_W = map_slice(POST_X, i, N_PLACES);

        if (!at_most_one(PRE_W) || !at_most_one(POST_W) ||
            (PRE_W != '0 && POST_W == '0)) begin : g_bad
            $error("msfsm_component_param: illegal PRE/POST slice for transition %0d", i);
        end

        assign member[i]   = (PRE_W != '0);
        assign t_en[i]     = |(PRE_W[N_PLACES-1:0] & p);
        assign post_tbl[i] = POST_W[N_PLACES-1:0];
    end

    assign cand = t_req & t_sync & t_en & {N_TRANS{~hold}};

    msfsm_prio_arb #(.N(N_TRANS)) u_arb (
        .req   (cand),
        .grant (grant)
    );

    // Reset wins over any firing in the same cycle
    assign fire = grant & {N_TRANS{reset}};

    // Only candidates blocked by the marking count as errors, never arbitration losers
    assign err_set = |(member & t_req & t_sync & ~t_en) & ~hold;

    always_comb begin
        p_nxt = p;
        for (int i = 0; i < N_TRANS; i++)
            if (fire[i]) p_nxt = post_tbl[i];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            p        <= INIT_MARK;
            fire_cnt <= '0;
            err      <= 1'b0;
        end else begin
            p <= p_nxt;
            if (|fire && fire_cnt != '1)
                fire_cnt <= fire_cnt + CNT_W'(1);
            if (err_set)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_msfsm_component_param.sv
// Directed bench: default ring (a), shared-place priority map (b), 2-bit counter (c).
module tb_msfsm_component_param;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] t_req, t_sync;
    logic       hold, err_clr;

    logic [3:0]  a_p, a_t_en, a_fire;
    logic [15:0] a_cnt;
    logic        a_err;
    logic [3:0]  b_p, b_t_en, b_fire;
    logic [15:0] b_cnt;
    logic        b_err;
    logic [3:0]  c_p, c_t_en, c_fire;
    logic [1:0]  c_cnt;
    logic        c_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    msfsm_component_param u_a (
        .clk(clk), .reset(reset), .t_req(t_req), .t_sync(t_sync), .hold(hold),
        .err_clr(err_clr), .p(a_p), .t_en(a_t_en), .fire(a_fire), .fire_cnt(a_cnt), .err(a_err)
    );

    // t0 and t2 both consume place 0
    msfsm_component_param #(.PRE(16'h8121)) u_b (
        .clk(clk), .reset(reset), .t_req(t_req), .t_sync(t_sync), .hold(hold),
        .err_clr(err_clr), .p(b_p), .t_en(b_t_en), .fire(b_fire), .fire_cnt(b_cnt), .err(b_err)
    );

    msfsm_component_param #(.CNT_W(2)) u_c (
        .clk(clk), .reset(reset), .t_req(t_req), .t_sync(t_sync), .hold(hold),
        .err_clr(err_clr), .p(c_p), .t_en(c_t_en), .fire(c_fire), .fire_cnt(c_cnt), .err(c_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        reset = 1'b0; t_req = '0; t_sync = 4'b1111; hold = 1'b0; err_clr = 1'b0;
        step();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; t_req = 4'b1111; t_sync = 4'b1111; hold = 1'b0; err_clr = 1'b0;
        #1;
        checks++; if (a_fire !== 4'b0000) begin errors++; $display("FAIL reset_fire got=%b exp=0000", a_fire); end
        step(); step();
        checks++; if (a_p !== 4'b0001) begin errors++; $display("FAIL reset_p got=%b exp=0001", a_p); end
        checks++; if (a_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", a_cnt); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", a_err); end
        @(negedge clk);
        reset = 1'b1; t_req = '0;
        #1;
        checks++; if (a_t_en !== 4'b0001) begin errors++; $display("FAIL idle_t_en got=%b exp=0001", a_t_en); end
        checks++; if (a_fire !== 4'b0000) begin errors++; $display("FAIL idle_fire got=%b exp=0000", a_fire); end
        step();
        checks++; if (a_p !== 4'b0001) begin errors++; $display("FAIL idle_p got=%b exp=0001", a_p); end
    endtask

    task automatic test_ring();
        logic [3:0] exp_p [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            t_req = 4'(1 << k); t_sync = 4'b1111;
            #1;
            checks++; if (a_fire !== 4'(1 << k)) begin errors++; $display("FAIL ring_fire%0d got=%b exp=%b", k, a_fire, 4'(1 << k)); end
            step();
            checks++; if (a_p !== exp_p[k]) begin errors++; $display("FAIL ring_p%0d got=%b exp=%b", k, a_p, exp_p[k]); end
        end
        @(negedge clk);
        t_req = '0;
        checks++; if (a_cnt !== 16'd4) begin errors++; $display("FAIL ring_cnt got=%0d exp=4", a_cnt); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL ring_err got=%b exp=0", a_err); end
    endtask

    task automatic test_err();
        @(negedge clk);
        t_req = 4'b0010; t_sync = 4'b1111;
        #1;
        checks++; if (a_fire !== 4'b0000) begin errors++; $display("FAIL err_fire got=%b exp=0000", a_fire); end
        step();
        checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL err_set got=%b exp=1", a_err); end
        checks++; if (a_p !== 4'b0001) begin errors++; $display("FAIL err_p got=%b exp=0001", a_p); end
        @(negedge clk);
        t_req = '0; err_clr = 1'b1;
        step();
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL err_clr got=%b exp=0", a_err); end
        @(negedge clk);
        t_req = 4'b0010; err_clr = 1'b1;
        step();
        checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL err_set_vs_clr got=%b exp=1", a_err); end
        @(negedge clk);
        t_req = '0; err_clr = 1'b1;
        step();
        @(negedge clk);
        err_clr = 1'b0;
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL err_reclr got=%b exp=0", a_err); end
    endtask

    task automatic test_block();
        @(negedge clk);
        t_req = 4'b0001; t_sync = 4'b0000; hold = 1'b0;
        #1;
        checks++; if (a_fire !== 4'b0000) begin errors++; $display("FAIL nosync_fire got=%b exp=0000", a_fire); end
        step();
        checks++; if (a_p !== 4'b0001) begin errors++; $display("FAIL nosync_p got=%b exp=0001", a_p); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL nosync_err got=%b exp=0", a_err); end
        @(negedge clk);
        t_req = 4'b0011; t_sync = 4'b1111; hold = 1'b1;
        #1;
        checks++; if (a_fire !== 4'b0000) begin errors++; $display("FAIL hold_fire got=%b exp=0000", a_fire); end
        step();
        checks++; if (a_p !== 4'b0001) begin errors++; $display("FAIL hold_p got=%b exp=0001", a_p); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL hold_err got=%b exp=0", a_err); end
        @(negedge clk);
        t_req = '0; hold = 1'b0;
    endtask

    task automatic test_priority();
        reset_pulse();
        t_req = 4'b0101; t_sync = 4'b1111;
        #1;
        checks++; if (b_fire !== 4'b0001) begin errors++; $display("FAIL prio_fire got=%b exp=0001", b_fire); end
        step();
        checks++; if (b_p !== 4'b0010) begin errors++; $display("FAIL prio_p got=%b exp=0010", b_p); end
        checks++; if (b_err !== 1'b0) begin errors++; $display("FAIL prio_err got=%b exp=0", b_err); end
        @(negedge clk);
        t_req = '0;
    endtask

    task automatic test_saturate();
        logic [1:0] exp_c;
        reset_pulse();
        for (int k = 0; k < 5; k++) begin
            t_req = 4'(1 << (k % 4)); t_sync = 4'b1111;
            step();
            exp_c = (k >= 2) ? 2'd3 : 2'(k + 1);
            checks++; if (c_cnt !== exp_c) begin errors++; $display("FAIL sat_cnt%0d got=%0d exp=%0d", k, c_cnt, exp_c); end
            @(negedge clk);
        end
        checks++; if (c_p !== 4'b0010) begin errors++; $display("FAIL sat_p got=%b exp=0010", c_p); end
        t_req = 4'b0010; reset = 1'b0;
        #1;
        checks++; if (c_fire !== 4'b0000) begin errors++; $display("FAIL rstfire_fire got=%b exp=0000", c_fire); end
        step();
        checks++; if (c_p !== 4'b0001) begin errors++; $display("FAIL rstfire_p got=%b exp=0001", c_p); end
        checks++; if (c_cnt !== 2'd0) begin errors++; $display("FAIL rstfire_cnt got=%0d exp=0", c_cnt); end
        @(negedge clk);
        reset = 1'b1; t_req = '0;
    endtask

    initial begin
        test_reset();
        test_ring();
        test_err();
        test_block();
        test_priority();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
